// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator op sequencer and its phase timer.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        LOAD,
        SHOW_ON,
        SHOW_OFF,
        ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_MOD = 2'b11
    } alu_op_t;

    localparam logic [3:0] BTN_ADD = 4'b0001;
    localparam logic [3:0] BTN_MUL = 4'b0010;
    localparam logic [3:0] BTN_DIV = 4'b0100;
    localparam logic [3:0] BTN_MOD = 4'b1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic alu_op_t btn_to_op(input logic [3:0] btn);
        case (btn)
            BTN_MUL: return OP_MUL;
            BTN_DIV: return OP_DIV;
            BTN_MOD: return OP_MOD;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_phase_timer.sv
// Phase counter shared by the WAIT timeout and the display blink phases.
// Clears to zero and counts up, holding once it reaches the runtime limit.
module calc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt != limit) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator sequencer: button press -> ALU start/done handshake -> result load -> blinking display.
// Define CALC_TIMEOUT_EN to bound the wait for alu_done by TIMEOUT_CYCLES.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int ON_CYCLES      = 50,
    parameter int OFF_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] button,
    input  logic       b_is_zero,
    input  logic       alu_done,
    output logic       alu_start,
    output logic [1:0] alu_op,
    output logic       load_inputs,
    output logic       ld_result,
    output logic       display,
    output logic       err,
    output logic       busy
);

    localparam int MAX_CYC = max3(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_CYCLES - 1);
`ifdef CALC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    seq_state_t       state_q, state_d;
    alu_op_t          op_q;
    logic [3:0]       btn_q;
    logic             accept;
    logic             div_by_zero;
    logic             tc;
    logic [CNT_W-1:0] limit;

    // A fresh one-hot edge from an all-released history, only in states that take a new op
    always_comb begin
        accept = 1'b0;
        if (btn_q == 4'b0000 && $onehot(button)) begin
            case (state_q)
                IDLE, SHOW_ON, SHOW_OFF, ERROR: accept = 1'b1;
                default:                        accept = 1'b0;
            endcase
        end
    end

    assign div_by_zero = op_q[1] && b_is_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            btn_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            btn_q   <= button;
            if (accept) begin
                op_q <= btn_to_op(button);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = ISSUE;
            ISSUE:    state_d = div_by_zero ? ERROR : WAIT;
            WAIT: begin
                if (alu_done) state_d = LOAD;
`ifdef CALC_TIMEOUT_EN
                else if (tc)  state_d = ERROR;
`endif
            end
            LOAD:     state_d = SHOW_ON;
            SHOW_ON:  if (accept) state_d = ISSUE; else if (tc) state_d = SHOW_OFF;
            SHOW_OFF: if (accept) state_d = ISSUE; else if (tc) state_d = SHOW_ON;
            ERROR:    if (accept) state_d = ISSUE;
            default:  state_d = IDLE;
        endcase
    end

    // One counter serves every timed state; it restarts on each state change
    always_comb begin
        limit = '0;
        case (state_q)
`ifdef CALC_TIMEOUT_EN
            WAIT:     limit = TO_LIM;
`endif
            SHOW_ON:  limit = ON_LIM;
            SHOW_OFF: limit = OFF_LIM;
            default:  limit = '0;
        endcase
    end

    calc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_d != state_q),
        .limit (limit),
        .tc    (tc)
    );

    always_comb begin
        alu_start   = 1'b0;
        load_inputs = 1'b0;
        ld_result   = 1'b0;
        display     = 1'b0;
        err         = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE:    load_inputs = 1'b1;
            ISSUE: begin
                busy      = 1'b1;
                alu_start = !div_by_zero;
            end
            WAIT:    busy      = 1'b1;
            LOAD:    ld_result = 1'b1;
            SHOW_ON: display   = 1'b1;
            ERROR:   err       = 1'b1;
            default: ;
        endcase
    end

    assign alu_op = op_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with an op scoreboard popped on each alu_start.
module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] button = 4'b0000;
    logic       b_is_zero = 1'b0;
    logic       alu_done = 1'b0;
    logic       alu_start, load_inputs, ld_result, display, err, busy;
    logic [1:0] alu_op;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_load = 0;
    logic [1:0] exp_q[$];

    calc_op_sequencer #(
        .ON_CYCLES      (4),
        .OFF_CYCLES     (6),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .b_is_zero   (b_is_zero),
        .alu_done    (alu_done),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .load_inputs (load_inputs),
        .ld_result   (ld_result),
        .display     (display),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge; every start pops the scoreboard
    task automatic cyc();
        logic [1:0] e;
        @(posedge clk);
        #1;
        if (alu_start === 1'b1) begin
            n_start++;
            check("start_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alu_op_at_start", 32'(alu_op), 32'(e));
            end
        end
        if (ld_result === 1'b1) n_load++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_inputs"}, 32'(load_inputs), 32'd1);
        check({tag, "_others"}, 32'({alu_start, ld_result, display, err, busy}), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        int s0, l0;

        // Reset
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check_reset_outputs("reset");

        // 1: add press held 3 cycles, done 3 cycles after start, blink pattern
        exp_q.push_back(2'b00);
        button = 4'b0001;
        cyc();
        check("t1_start", 32'(alu_start), 32'd1);
        check("t1_busy_issue", 32'(busy), 32'd1);
        cyc();
        cyc();
        button = 4'b0000;
        alu_done = 1'b1;
        cyc();
        alu_done = 1'b0;
        check("t1_ld_result", 32'(ld_result), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("t1_display_%0d", i), 32'(display), 32'(i < 4));
        end
        cyc();
        check("t1_display_repeat", 32'(display), 32'd1);
        check("t1_counts", 32'({n_start[3:0], n_load[3:0]}), 32'h11);

        // 2: divide by zero from SHOW_ON, then recover with add
        b_is_zero = 1'b1;
        button = 4'b0100;
        cyc();
        check("t2_busy_issue", 32'(busy), 32'd1);
        check("t2_no_start", 32'(alu_start), 32'd0);
        cyc();
        check("t2_err", 32'(err), 32'd1);
        check("t2_display_off", 32'(display), 32'd0);
        button = 4'b0000;
        b_is_zero = 1'b0;
        cyc();
        check("t2_err_held", 32'(err), 32'd1);
        exp_q.push_back(2'b00);
        button = 4'b0001;
        cyc();
        button = 4'b0000;
        check("t2_err_clear", 32'(err), 32'd0);
        check("t2_start", 32'(alu_start), 32'd1);
        cyc();
        alu_done = 1'b1;
        cyc();
        alu_done = 1'b0;
        check("t2_ld_result", 32'(ld_result), 32'd1);
        cyc();

        // 3: multiply with no done; then done on the last WAIT cycle
        exp_q.push_back(2'b01);
        button = 4'b0010;
        cyc();
        button = 4'b0000;
        check("t3_busy_issue", 32'(busy), 32'd1);
`ifdef CALC_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("t3_busy_wait_%0d", i), 32'(busy), 32'd1);
        end
        cyc();
        check("t3_timeout_err", 32'(err), 32'd1);
        check("t3_timeout_idle", 32'(busy), 32'd0);
        exp_q.push_back(2'b01);
        button = 4'b0010;
        cyc();
        button = 4'b0000;
        for (int i = 0; i < 8; i++) cyc();
        check("t3_last_wait_busy", 32'(busy), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            cyc();
            check($sformatf("t3_busy_wait_%0d", i), 32'(busy), 32'd1);
        end
`endif
        alu_done = 1'b1;
        cyc();
        alu_done = 1'b0;
        check("t3_done_wins", 32'({ld_result, err}), 32'b10);
        cyc();

        // 4: multi-hot ignored, held single press accepted once
        s0 = n_start;
        l0 = n_load;
        button = 4'b0011;
        cyc();
        check("t4_multi1_ignored", 32'(busy), 32'd0);
        button = 4'b0000;
        cyc();
        button = 4'b1100;
        cyc();
        check("t4_multi2_ignored", 32'(busy), 32'd0);
        button = 4'b0000;
        cyc();
        exp_q.push_back(2'b11);
        button = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            alu_done = (i == 3);
            cyc();
        end
        alu_done = 1'b0;
        button = 4'b0000;
        check("t4_one_start", 32'(n_start - s0), 32'd1);
        check("t4_one_load", 32'(n_load - l0), 32'd1);
        check("t4_alu_op", 32'(alu_op), 32'd3);

        // 5: stray done in IDLE ignored; press in SHOW_OFF restarts at ISSUE
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        alu_done = 1'b1;
        cyc();
        alu_done = 1'b0;
        check("t5_stray_done", 32'({load_inputs, ld_result, busy}), 32'b100);
        exp_q.push_back(2'b00);
        button = 4'b0001;
        cyc();
        button = 4'b0000;
        cyc();
        alu_done = 1'b1;
        cyc();
        alu_done = 1'b0;
        cyc();
        repeat (4) cyc();
        check("t5_in_show_off", 32'({display, busy, err}), 32'd0);
        exp_q.push_back(2'b01);
        button = 4'b0010;
        cyc();
        button = 4'b0000;
        check("t5_restart_issue", 32'({alu_start, busy}), 32'b11);

        // 6: reset during WAIT, late done ignored
        cyc();
        check("t6_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_reset_outputs("t6_reset");
        alu_done = 1'b1;
        cyc();
        alu_done = 1'b0;
        check_reset_outputs("t6_late_done");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
